// File: rtl/fsk_pkg.sv
// fsk_pkg: shared constants and types for the FSK transmitter
package fsk_pkg;
  localparam int SINE_AMP = 100;
  localparam int PHASE_MOD = 360;
  typedef enum logic {IDLE, SEND} state_t;
  typedef logic signed [7:0] sample_t;
endpackage

// File: rtl/fsk_modulator_if.sv
// fsk_modulator_if: bit-input handshake and sample output of the FSK transmitter
interface fsk_modulator_if;
  import fsk_pkg::*;
  logic bit_i;
  logic bit_valid_i;
  logic bit_ready_o;
  sample_t sample_o;
  logic sample_valid_o;
  modport master (output bit_i, bit_valid_i, input bit_ready_o, sample_o, sample_valid_o);
  modport slave (input bit_i, bit_valid_i, output bit_ready_o, sample_o, sample_valid_o);
endinterface

// File: rtl/fsk_sine_rom.sv
// fsk_sine_rom: quarter-wave sine lookup, degrees in, amplitude-100 sample out
module fsk_sine_rom
  import fsk_pkg::*;
(
  input  logic [8:0] phase_i,
  output sample_t    sample_o
);
  localparam logic [6:0] Q [91] = '{
    7'd0,  7'd1,  7'd3,  7'd5,  7'd6,  7'd8,  7'd10, 7'd12, 7'd13, 7'd15,
    7'd17, 7'd19, 7'd20, 7'd22, 7'd24, 7'd25, 7'd27, 7'd29, 7'd30, 7'd32,
    7'd34, 7'd35, 7'd37, 7'd39, 7'd40, 7'd42, 7'd43, 7'd45, 7'd46, 7'd48,
    7'd49, 7'd51, 7'd52, 7'd54, 7'd55, 7'd57, 7'd58, 7'd60, 7'd61, 7'd62,
    7'd64, 7'd65, 7'd66, 7'd68, 7'd69, 7'd70, 7'd71, 7'd73, 7'd74, 7'd75,
    7'd76, 7'd77, 7'd78, 7'd79, 7'd80, 7'd81, 7'd82, 7'd83, 7'd84, 7'd85,
    7'd86, 7'd87, 7'd88, 7'd89, 7'd89, 7'd90, 7'd91, 7'd92, 7'd92, 7'd93,
    7'd93, 7'd94, 7'd95, 7'd95, 7'd96, 7'd96, 7'd97, 7'd97, 7'd97, 7'd98,
    7'd98, 7'd98, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99,
    7'd100
  };
  logic [6:0] idx;
  logic [6:0] mag;
  logic       neg;
  // fold the phase into the first quadrant, then restore the sign
  always_comb begin
    neg = phase_i > 9'd180;
    idx = phase_i <= 9'd90  ? 7'(phase_i) :
          phase_i <= 9'd180 ? 7'(9'd180 - phase_i) :
          phase_i <= 9'd270 ? 7'(phase_i - 9'd180) : 7'(9'd360 - phase_i);
    mag = Q[idx];
    sample_o = neg ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  end
endmodule

// File: rtl/fsk_modulator.sv
// fsk_modulator: continuous-phase FSK transmitter, one sine sample per clock
module fsk_modulator
  import fsk_pkg::*;
#(
  parameter int SPB        = 360,
  parameter int MARK_STEP  = 4,
  parameter int SPACE_STEP = 2
) (
  input logic Clk,
  input logic Rst_n,
  fsk_modulator_if.slave bus
);
  localparam logic [9:0] CNT_LAST = 10'(SPB - 1);
  localparam logic [8:0] MARK     = 9'(MARK_STEP);
  localparam logic [8:0] SPACE    = 9'(SPACE_STEP);
  state_t     state_q, state_d;
  logic [9:0] cnt_q, cnt_d;
  logic [8:0] phase_q, phase_d;
  logic [8:0] step_q, step_d;
  logic [9:0] sum;
  sample_t    sample_q, sample_d, rom_out;
  logic       valid_q, valid_d;
  logic       last, ready, accept;
  assign last   = state_q == SEND && cnt_q == CNT_LAST;
  assign accept = bus.bit_valid_i && ready;
  assign sum    = {1'b0, phase_q} + {1'b0, step_q};
  fsk_sine_rom u_rom (.phase_i(phase_q), .sample_o(rom_out));
  // state register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end
  // next state: a new bit keeps us sending, otherwise leave after the last sample
  always_comb state_d = accept || (state_q == SEND && !last) ? SEND : IDLE;
  // FSM output: ready when idle or on the last sample of the current bit
  always_comb ready = state_q == IDLE || last;
  // datapath next values; idle forces phase to 0 so each burst starts at 0 degrees
  always_comb begin
    cnt_d    = state_q == SEND && !last ? cnt_q + 10'd1 : '0;
    step_d   = accept ? (bus.bit_i ? MARK : SPACE) : step_q;
    phase_d  = state_q != SEND ? '0 :
               sum >= 10'(PHASE_MOD) ? 9'(sum - 10'(PHASE_MOD)) : sum[8:0];
    sample_d = state_q == SEND ? rom_out : '0;
    valid_d  = state_q == SEND;
  end
  // datapath registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q    <= '0;
      step_q   <= '0;
      phase_q  <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      step_q   <= step_d;
      phase_q  <= phase_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
    end
  end
  assign bus.bit_ready_o    = ready;
  assign bus.sample_o       = sample_q;
  assign bus.sample_valid_o = valid_q;
endmodule
